// File: rtl/pending_encoder_8to3_if.sv
// pending_encoder_8to3_if: request/event handshake bundle between event sources,
// the encoder and its consumer.
interface pending_encoder_8to3_if;
    logic [7:0] req;
    logic       en;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       overrun;

    modport master (
        output req, en, ready,
        input  code, valid, pending, overrun
    );

    modport slave (
        input  req, en, ready,
        output code, valid, pending, overrun
    );
endinterface

// File: rtl/pending_encoder_8to3.sv
// pending_encoder_8to3: latches rising edges on eight request lines and presents
// them one at a time as a 3-bit priority-encoded index on a valid/ready handshake.
module pending_encoder_8to3 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    pending_encoder_8to3_if.slave  bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q, req_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic       overrun_q, overrun_d;
    logic [7:0] rise, clear;
    logic [2:0] win;
    logic       load;

    // Later iterations overwrite earlier ones, so the last set bit visited wins.
    always_comb begin
        win = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++)
                if (pending_q[i]) win = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (pending_q[i]) win = 3'(i);
        end
    end

    always_comb begin
        req_d     = bus.req;
        rise      = bus.en ? (bus.req & ~req_q) : 8'h00;
        state_d   = state_q;
        code_d    = code_q;
        clear     = 8'h00;
        load      = (|pending_q) && (state_q == IDLE || bus.ready);
        if (load) begin
            code_d  = win;
            clear   = 8'h01 << win;
            state_d = PRESENT;
        end else if (state_q == PRESENT && bus.ready) begin
            state_d = IDLE;
        end
        pending_d = (pending_q & ~clear) | rise;
        overrun_d = |(rise & pending_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 8'h00;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = (state_q == PRESENT);
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_pending_encoder_8to3.sv
// tb_pending_encoder_8to3: directed scenarios against both priority orders of the
// edge-capturing 8-to-3 encoder.
module tb_pending_encoder_8to3;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       en = 1'b1;
    logic       ready = 1'b0;
    int         total = 0;
    int         bad = 0;

    pending_encoder_8to3_if b0 ();
    pending_encoder_8to3_if b1 ();

    assign b0.req = req;
    assign b0.en = en;
    assign b0.ready = ready;
    assign b1.req = req;
    assign b1.en = en;
    assign b1.ready = ready;

    pending_encoder_8to3 #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    pending_encoder_8to3 #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        en = 1'b1;
        ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({b0.code, b0.valid, b0.pending, b0.overrun} !== 13'h0) begin
            bad++;
            $display("FAIL reset: code=%0d valid=%b pending=%h overrun=%b, want all 0",
                     b0.code, b0.valid, b0.pending, b0.overrun);
        end
        tick();
        total++;
        if (b0.valid !== 1'b0 || b0.pending !== 8'h00) begin
            bad++;
            $display("FAIL reset_idle: valid=%b pending=%h, want 0/00", b0.valid, b0.pending);
        end
    endtask

    task automatic test_release_edge();
        rst = 1'b1;
        req = 8'h10;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (b0.pending !== 8'h10) begin
            bad++;
            $display("FAIL release_edge: pending=%h, want 10", b0.pending);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h08;
        tick();
        total++;
        if (b0.pending !== 8'h08 || b0.valid !== 1'b0) begin
            bad++;
            $display("FAIL single_e1: pending=%h valid=%b, want 08/0", b0.pending, b0.valid);
        end
        ready = 1'b1;
        tick();
        total++;
        if (b0.valid !== 1'b1 || b0.code !== 3'd3 || b0.pending !== 8'h00) begin
            bad++;
            $display("FAIL single_e2: valid=%b code=%0d pending=%h, want 1/3/00",
                     b0.valid, b0.code, b0.pending);
        end
        tick();
        total++;
        if (b0.valid !== 1'b0) begin
            bad++;
            $display("FAIL single_e3: valid=%b, want 0", b0.valid);
        end
    endtask

    task automatic test_priority();
        logic [2:0] e0 [3];
        logic [2:0] e1 [3];
        e0 = '{3'd0, 3'd4, 3'd7};
        e1 = '{3'd7, 3'd4, 3'd0};
        do_reset();
        ready = 1'b1;
        req = 8'h91;
        tick();
        total++;
        if (b0.pending !== 8'h91 || b1.pending !== 8'h91) begin
            bad++;
            $display("FAIL prio_capture: pending=%h/%h, want 91/91", b0.pending, b1.pending);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (b0.valid !== 1'b1 || b0.code !== e0[k]) begin
                bad++;
                $display("FAIL prio_lsb[%0d]: valid=%b code=%0d, want 1/%0d", k, b0.valid, b0.code, e0[k]);
            end
            total++;
            if (b1.valid !== 1'b1 || b1.code !== e1[k]) begin
                bad++;
                $display("FAIL prio_msb[%0d]: valid=%b code=%0d, want 1/%0d", k, b1.valid, b1.code, e1[k]);
            end
        end
        tick();
        total++;
        if (b0.valid !== 1'b0 || b1.valid !== 1'b0) begin
            bad++;
            $display("FAIL prio_end: valid=%b/%b, want 0/0", b0.valid, b1.valid);
        end
    endtask

    task automatic test_backpressure();
        int stable_bad;
        stable_bad = 0;
        do_reset();
        req = 8'h20;
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            req = (k == 3) ? 8'h24 : 8'h20;
            tick();
            if (b0.valid !== 1'b1 || b0.code !== 3'd5) stable_bad++;
        end
        total++;
        if (stable_bad != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d cycles lost code 5, want 0", stable_bad);
        end
        total++;
        if (b0.pending !== 8'h04) begin
            bad++;
            $display("FAIL bp_pending: pending=%h, want 04", b0.pending);
        end
        ready = 1'b1;
        tick();
        total++;
        if (b0.valid !== 1'b1 || b0.code !== 3'd2 || b0.pending !== 8'h00) begin
            bad++;
            $display("FAIL bp_release: valid=%b code=%0d pending=%h, want 1/2/00",
                     b0.valid, b0.code, b0.pending);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        req = 8'h40;
        tick();
        tick();
        req = 8'h42;
        tick();
        req = 8'h40;
        tick();
        total++;
        if (b0.overrun !== 1'b0 || b0.pending !== 8'h02 || b0.code !== 3'd6) begin
            bad++;
            $display("FAIL ovr_setup: overrun=%b pending=%h code=%0d, want 0/02/6",
                     b0.overrun, b0.pending, b0.code);
        end
        req = 8'h42;
        tick();
        total++;
        if (b0.overrun !== 1'b1 || b0.pending !== 8'h02) begin
            bad++;
            $display("FAIL ovr_pulse: overrun=%b pending=%h, want 1/02", b0.overrun, b0.pending);
        end
        tick();
        total++;
        if (b0.overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_width: overrun=%b, want 0", b0.overrun);
        end
        req = 8'h02;
        tick();
        req = 8'h42;
        tick();
        total++;
        if (b0.overrun !== 1'b0 || b0.pending !== 8'h42 || b0.code !== 3'd6) begin
            bad++;
            $display("FAIL ovr_same_code: overrun=%b pending=%h code=%0d, want 0/42/6",
                     b0.overrun, b0.pending, b0.code);
        end
    endtask

    task automatic test_enable();
        do_reset();
        ready = 1'b1;
        en = 1'b0;
        tick();
        req = 8'h08;
        tick();
        tick();
        en = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if (b0.valid !== 1'b0 || b0.pending !== 8'h00) begin
            bad++;
            $display("FAIL enable_gate: valid=%b pending=%h, want 0/00", b0.valid, b0.pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h0F;
        tick();
        tick();
        req = 8'h0E;
        tick();
        req = 8'h0F;
        tick();
        total++;
        if (b0.valid !== 1'b1 || b0.pending !== 8'h0F) begin
            bad++;
            $display("FAIL mid_setup: valid=%b pending=%h, want 1/0F", b0.valid, b0.pending);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (b0.valid !== 1'b0 || b0.pending !== 8'h00 || b0.overrun !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: valid=%b pending=%h overrun=%b, want 0/00/0",
                     b0.valid, b0.pending, b0.overrun);
        end
        req = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (b0.valid !== 1'b0 || b0.pending !== 8'h00) begin
            bad++;
            $display("FAIL mid_after: valid=%b pending=%h, want 0/00", b0.valid, b0.pending);
        end
    endtask

    initial begin
        test_reset();
        test_release_edge();
        test_single();
        test_priority();
        test_backpressure();
        test_overrun();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
